dmem_arbiter: RTL

Shares the single-port data memory between the pipeline's MEM stage and a debug/loader port. It grants one access per cycle with round-robin fairness on contention, and raises `cpu_stall` to freeze the pipeline whenever the MEM-stage request is not granted. It also supports a bounded debug lock for burst loads and dumps, and routes read data back with a fixed one-cycle latency. It sits between the MEM stage and `data_mem`.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM stage
// and the debug/loader port, with a bounded debug lock and 1-cycle read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       r_state;
  logic             r_prio_q;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_rd_pend_q;
  logic             r_rd_own_q;

  logic w_cpu_gnt;
  logic w_dbg_gnt;
  logic w_lock_done;
  logic w_rd_gnt;

  // Zero-cycle grant from the requests and registered arbitration state.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!reset) begin
      if (r_state == LOCKED) begin
        w_dbg_gnt = dbg_req;
      end else if (cpu_req && (!dbg_req || (r_prio_q == PORT_CPU))) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_dbg_gnt = dbg_req;
      end
    end
  end

  assign w_lock_done = (r_lock_cnt == CNT_W'(LOCK_MAX));
  assign w_rd_gnt    = mem_en & ~mem_we;

  // Memory-side mux: idle bus is driven to zero.
  always_comb begin
    mem_en    = w_cpu_gnt | w_dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid = ~reset & r_rd_pend_q & (r_rd_own_q == PORT_CPU);
  assign dbg_rvalid = ~reset & r_rd_pend_q & (r_rd_own_q == PORT_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  // Arbitration state, lock counter and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_prio_q    <= PORT_CPU;
      r_lock_cnt  <= '0;
      r_rd_pend_q <= 1'b0;
      r_rd_own_q  <= PORT_CPU;
    end else begin
      r_rd_pend_q <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_own_q <= w_dbg_gnt ? PORT_DBG : PORT_CPU;
      end
      if (r_state == ARB) begin
        if (w_cpu_gnt) begin
          r_prio_q <= PORT_DBG;
        end else if (w_dbg_gnt) begin
          r_prio_q <= PORT_CPU;
        end
        if (w_dbg_gnt && dbg_lock) begin
          r_state    <= LOCKED;
          r_lock_cnt <= CNT_W'(1);
        end
      end else begin
        if (!w_lock_done) begin
          r_lock_cnt <= r_lock_cnt + CNT_W'(1);
        end
        // Exhausting the lock hands the next contention to the CPU.
        if (!dbg_lock || w_lock_done) begin
          r_state    <= ARB;
          r_lock_cnt <= '0;
          if (w_lock_done) begin
            r_prio_q <= PORT_CPU;
          end
        end
      end
    end
  end

endmodule
